// File: rtl/pack_fifo_pkg.sv
// Shared definitions for the pair-packing FIFO: pack state encoding and
// default geometry used by the top level and its control sub-module.
package pack_fifo_pkg;

  // NONE: no narrow item waiting; HIGH: upper half captured, waiting for low.
  typedef enum logic {
    NONE = 1'b0,
    HIGH = 1'b1
  } pack_state_t;

  localparam int PKG_DATA_WIDTH = 8;
  localparam int PKG_ADDR_WIDTH = 4;

endpackage : pack_fifo_pkg

// File: rtl/fifo_ctrl.sv
// Pointer, word-count and status-flag control for pack_fifo.
// Owns the pack state machine and produces the load/commit strobes that
// steer the pending register and the storage write in the top level.
module fifo_ctrl
  import pack_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = PKG_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  load,
  output logic                  commit,
  output logic [ADDR_WIDTH-1:0] w_ptr,
  output logic [ADDR_WIDTH-1:0] r_ptr,
  output logic                  empty,
  output logic                  full,
  output logic                  half
);

  // A count equal to the depth is flagged by the single extra MSB.
  localparam logic [ADDR_WIDTH:0] CNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  pack_state_t           state;
  pack_state_t           state_next;
  logic [ADDR_WIDTH:0]   count;
  logic                  wr_acc;
  logic                  rd_acc;

  // Flags derive from registered state only, so they never depend on this
  // cycle's wr/rd and the accept terms below cannot form a loop.
  assign empty  = (count == '0);
  assign half   = (state == HIGH);
  assign full   = (count == CNT_MAX) && (state == HIGH);

  // An empty FIFO cannot pop, so a rd coinciding with the first commit is
  // dropped; a full FIFO cannot accept, so wr is dropped while full.
  assign wr_acc = wr && !full;
  assign rd_acc = rd && !empty;

  // Pack state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= NONE;
    end else begin
      state <= state_next;
    end
  end

  // Next pack state and the load/commit strobes for the datapath.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    commit     = 1'b0;
    unique case (state)
      NONE: begin
        if (wr_acc) begin
          load       = 1'b1;
          state_next = HIGH;
        end
      end
      HIGH: begin
        if (wr_acc) begin
          commit     = 1'b1;
          state_next = NONE;
        end
      end
      default: state_next = NONE;
    endcase
  end

  // Write pointer advances once per committed wide word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_ptr <= '0;
    end else if (commit) begin
      w_ptr <= w_ptr + ADDR_WIDTH'(1);
    end
  end

  // Read pointer advances once per accepted pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (rd_acc) begin
      r_ptr <= r_ptr + ADDR_WIDTH'(1);
    end
  end

  // Word count; a simultaneous commit and pop leave it unchanged. A commit
  // cannot occur at full depth because that condition also raises full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      unique case ({commit, rd_acc})
        2'b10:   count <= count + (ADDR_WIDTH + 1)'(1);
        2'b01:   count <= count - (ADDR_WIDTH + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule : fifo_ctrl

// File: rtl/pack_fifo.sv
// Pair-packing FIFO: accepts narrow items, packs two into one wide word
// (first item in the upper half) and serves wide words in order with a
// zero-latency combinational read port.
module pack_fifo
  import pack_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = PKG_DATA_WIDTH,
  parameter int ADDR_WIDTH = PKG_ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr,
  input  logic [DATA_WIDTH-1:0]   w_data,
  input  logic                    rd,
  output logic [2*DATA_WIDTH-1:0] r_data,
  output logic                    empty,
  output logic                    full,
  output logic                    half
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [2*DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0]   pending;
  logic [ADDR_WIDTH-1:0]   w_ptr;
  logic [ADDR_WIDTH-1:0]   r_ptr;
  logic                    load;
  logic                    commit;

  fifo_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ctrl (
    .clk    (clk),
    .reset  (reset),
    .wr     (wr),
    .rd     (rd),
    .load   (load),
    .commit (commit),
    .w_ptr  (w_ptr),
    .r_ptr  (r_ptr),
    .empty  (empty),
    .full   (full),
    .half   (half)
  );

  // Pending upper half; cleared on reset so a half-built pair is discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else if (load) begin
      pending <= w_data;
    end
  end

  // Storage write of the completed pair; contents survive reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      mem[w_ptr] <= {pending, w_data};
    end
  end

  assign r_data = mem[r_ptr];

endmodule : pack_fifo

// File: tb/tb_pack_fifo.sv
// Self-checking bench for pack_fifo (DATA_WIDTH=8, ADDR_WIDTH=4): directed
// scenarios plus randomized traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_pack_fifo;

  logic        clk;
  logic        reset;
  logic        wr;
  logic [7:0]  w_data;
  logic        rd;
  logic [15:0] r_data;
  logic        empty;
  logic        full;
  logic        half;

  int n_vec;
  int n_err;

  // Reference model: committed words in order plus the pending half.
  logic [15:0] q[$];
  logic        m_half;
  logic [7:0]  m_pend;

  pack_fifo #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .wr     (wr),
    .w_data (w_data),
    .rd     (rd),
    .r_data (r_data),
    .empty  (empty),
    .full   (full),
    .half   (half)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare all outputs against the model state before the coming edge.
  task automatic check_model(input string tag);
    logic m_empty;
    logic m_full;
    m_empty = (q.size() == 0);
    m_full  = (q.size() == 16) && m_half;
    check({tag, ".empty"}, 32'(empty), 32'(m_empty));
    check({tag, ".full"},  32'(full),  32'(m_full));
    check({tag, ".half"},  32'(half),  32'(m_half));
    if (!m_empty) check({tag, ".r_data"}, 32'(r_data), 32'(q[0]));
  endtask

  // One clock cycle: drive inputs just after negedge, check, then advance.
  task automatic step(input logic w, input logic [7:0] d, input logic r, input string tag);
    logic wacc;
    logic racc;
    wr = w; w_data = d; rd = r;
    #1;
    check_model(tag);
    wacc = w && !((q.size() == 16) && m_half);
    racc = r && (q.size() != 0);
    if (racc) void'(q.pop_front());
    if (wacc) begin
      if (m_half) begin
        q.push_back({m_pend, d});
        m_half = 1'b0;
      end else begin
        m_pend = d;
        m_half = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asynchronous reset asserted mid-cycle; flags must react without a clock.
  task automatic do_reset(input string tag);
    wr = 1'b0; rd = 1'b0; w_data = 8'h00;
    reset = 1'b1;
    #1;
    check({tag, ".rst_empty"}, 32'(empty), 32'd1);
    check({tag, ".rst_full"},  32'(full),  32'd0);
    check({tag, ".rst_half"},  32'(half),  32'd0);
    q.delete();
    m_half = 1'b0;
    m_pend = 8'h00;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check({tag, ".post_empty"}, 32'(empty), 32'd1);
    check({tag, ".post_half"},  32'(half),  32'd0);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    q.delete(); m_half = 1'b0; m_pend = 8'h00;
    reset = 1'b1; wr = 1'b0; rd = 1'b0; w_data = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Basic pair
    do_reset("init");
    step(1'b1, 8'hAB, 1'b0, "ab");
    check("ab.half", 32'(half), 32'd1);
    check("ab.empty", 32'(empty), 32'd1);
    step(1'b1, 8'hCD, 1'b0, "cd");
    check("cd.empty", 32'(empty), 32'd0);
    check("cd.r_data", 32'(r_data), 32'h0000ABCD);
    step(1'b0, 8'h00, 1'b1, "pop_abcd");
    step(1'b0, 8'h00, 1'b0, "idle0");

    // Fill to full, overflow attempt, drain in order
    do_reset("fill");
    for (int i = 0; i < 32; i++) step(1'b1, 8'(i), 1'b0, "fill");
    check("fill.full_before", 32'(full), 32'd0);
    step(1'b1, 8'hFF, 1'b0, "w33");
    check("w33.full", 32'(full), 32'd1);
    step(1'b1, 8'hEE, 1'b0, "w34");
    check("w34.full", 32'(full), 32'd1);
    for (int i = 0; i < 16; i++) begin
      #0;
      check("drain.r_data", 32'(r_data), 32'({8'(2*i), 8'(2*i+1)}));
      step(1'b0, 8'h00, 1'b1, "drain");
    end
    check("drain.empty", 32'(empty), 32'd1);
    check("drain.half", 32'(half), 32'd1);
    step(1'b1, 8'h01, 1'b0, "tail");
    check("tail.r_data", 32'(r_data), 32'h0000FF01);

    // Full with simultaneous rd and wr
    do_reset("fullrw");
    for (int i = 0; i < 33; i++) step(1'b1, 8'(i + 8'h40), 1'b0, "fillrw");
    check("fullrw.full", 32'(full), 32'd1);
    step(1'b1, 8'h77, 1'b1, "rw");
    check("rw.full", 32'(full), 32'd0);
    check("rw.count", 32'(dut.u_ctrl.count), 32'd15);
    check("rw.half", 32'(half), 32'd1);
    check("rw.r_data", 32'(r_data), 32'h00004243);
    step(1'b1, 8'h99, 1'b0, "rw_cmp");
    check("rw_cmp.word", 32'(dut.mem[0]), 32'h00006099);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, "rwdrain");

    // rd on empty and rd coincident with first commit
    do_reset("rdempty");
    step(1'b0, 8'h00, 1'b1, "rd_e");
    check("rd_e.rptr", 32'(dut.u_ctrl.r_ptr), 32'd0);
    check("rd_e.empty", 32'(empty), 32'd1);
    step(1'b1, 8'h11, 1'b1, "rd_e1");
    step(1'b1, 8'h22, 1'b1, "rd_c");
    check("rd_c.rptr", 32'(dut.u_ctrl.r_ptr), 32'd0);
    check("rd_c.empty", 32'(empty), 32'd0);
    check("rd_c.r_data", 32'(r_data), 32'h00001122);
    step(1'b0, 8'h00, 1'b1, "rd_pop");

    // Reset mid-pair with stored words
    do_reset("midrst");
    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, "mid_fill");
    check("mid.half", 32'(half), 32'd1);
    check("mid.count", 32'(dut.u_ctrl.count), 32'd3);
    do_reset("midrst2");
    step(1'b1, 8'h12, 1'b0, "p12");
    step(1'b1, 8'h34, 1'b0, "p34");
    check("p34.r_data", 32'(r_data), 32'h00001234);
    step(1'b0, 8'h00, 1'b1, "p_pop");

    // 40 pairs with interleaved reads, forcing pointer wrap
    do_reset("wrap");
    begin
      int pushed;
      pushed = 0;
      while (pushed < 80) begin
        logic w;
        w = ($urandom_range(0, 3) != 0);
        if (w && !full) pushed++;
        step(w, 8'($urandom), ($urandom_range(0, 2) == 0), "wrap");
      end
      for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1, "wrapdrain");
      check("wrap.empty", 32'(empty), 32'd1);
    end

    // Free-running random traffic with phases biased to fill and drain
    for (int ph = 0; ph < 8; ph++) begin
      for (int i = 0; i < 150; i++) begin
        logic w;
        logic r;
        if (ph[0]) begin
          w = ($urandom_range(0, 3) == 0);
          r = ($urandom_range(0, 3) != 0);
        end else begin
          w = ($urandom_range(0, 3) != 0);
          r = ($urandom_range(0, 4) == 0);
        end
        step(w, 8'($urandom), r, "rand");
      end
      if (ph == 5) do_reset("randrst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_pack_fifo
